// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial pattern detector with saturating match counter and sticky LED
// Samples din on each step strobe into an N-bit history and flags matches against PATTERN.
module seq_detector #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter bit           OVERLAP = 1'b1
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         step,
  input  logic         din,
  input  logic         clear,
  output logic         detect,
  output logic         match_led,
  output logic [7:0]   match_count,
  output logic [3:0]   fill,
  output logic [N-1:0] hist
);

  localparam logic [3:0] FULL = 4'(N);

  logic [N-1:0] hist_q, hist_d;
  logic [3:0]   fill_q, fill_d;
  logic [7:0]   count_q;
  logic         detect_q;
  logic         led_q;
  logic         match;

  // History and fill as they would be after the current sample is taken.
  always_comb begin
    hist_d = {hist_q[N-2:0], din};
    fill_d = (fill_q == FULL) ? fill_q : fill_q + 4'd1;
    match  = (fill_d == FULL) && (hist_d == PATTERN);
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      detect_q <= 1'b0;
      led_q    <= 1'b0;
    end else if (clear) begin
      hist_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      detect_q <= 1'b0;
      led_q    <= 1'b0;
    end else if (step) begin
      hist_q   <= hist_d;
      detect_q <= match;
      if (match) begin
        led_q   <= 1'b1;
        count_q <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        // Non-overlapping mode forces a full refill before the next match.
        fill_q  <= OVERLAP ? fill_d : 4'd0;
      end else begin
        fill_q  <= fill_d;
      end
    end else begin
      detect_q <= 1'b0;
    end
  end

  assign hist        = hist_q;
  assign fill        = fill_q;
  assign match_count = count_q;
  assign detect      = detect_q;
  assign match_led   = led_q;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - directed self-checking bench for seq_detector
// Three instances share stimulus: default, non-overlapping, and all-ones pattern.
module tb_seq_detector;

  logic clk_in = 1'b0;
  logic rst, step, din, clear;

  logic       a_det, a_led, b_det, b_led, c_det, c_led;
  logic [7:0] a_cnt, b_cnt, c_cnt;
  logic [3:0] a_fill, b_fill, c_fill;
  logic [3:0] a_hist, b_hist, c_hist;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_a (
    .clk_in(clk_in), .rst(rst), .step(step), .din(din), .clear(clear),
    .detect(a_det), .match_led(a_led), .match_count(a_cnt), .fill(a_fill), .hist(a_hist));

  seq_detector #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u_b (
    .clk_in(clk_in), .rst(rst), .step(step), .din(din), .clear(clear),
    .detect(b_det), .match_led(b_led), .match_count(b_cnt), .fill(b_fill), .hist(b_hist));

  seq_detector #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_c (
    .clk_in(clk_in), .rst(rst), .step(step), .din(din), .clear(clear),
    .detect(c_det), .match_led(c_led), .match_count(c_cnt), .fill(c_fill), .hist(c_hist));

  task automatic do_step(input logic b);
    step = 1'b1; din = b;
    @(posedge clk_in); #1;
    step = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk_in); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; step = 1'b0; din = 1'b0; clear = 1'b0;
    #12;
    checks++;
    if ({a_det, a_led, a_cnt, a_fill, a_hist} !== 18'd0) begin
      $display("FAIL reset_state actual=%h required=0", {a_det, a_led, a_cnt, a_fill, a_hist});
      errors++;
    end
    rst = 1'b1;
    @(posedge clk_in); #1;
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      do_step(bits[3-i]);
      checks++;
      if (a_fill !== 4'(i + 1)) begin
        $display("FAIL basic_fill step=%0d actual=%0d required=%0d", i + 1, a_fill, i + 1);
        errors++;
      end
      checks++;
      if (a_det !== (i == 3)) begin
        $display("FAIL basic_detect step=%0d actual=%b required=%b", i + 1, a_det, i == 3);
        errors++;
      end
    end
    checks++;
    if ({a_cnt, a_led, a_hist} !== {8'd1, 1'b1, 4'b1101}) begin
      $display("FAIL basic_result actual cnt=%0d led=%b hist=%b required cnt=1 led=1 hist=1101",
               a_cnt, a_led, a_hist);
      errors++;
    end
    @(posedge clk_in); #1;
    checks++;
    if (a_det !== 1'b0) begin
      $display("FAIL basic_detect_one_cycle actual=%b required=0", a_det);
      errors++;
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [6:0] exp_a, exp_b, got_a, got_b;
    stream = 7'b1101101;
    exp_a  = 7'b0001001;
    exp_b  = 7'b0001000;
    do_clear();
    for (int i = 0; i < 7; i++) begin
      do_step(stream[6-i]);
      got_a[6-i] = a_det;
      got_b[6-i] = b_det;
    end
    checks++;
    if (got_a !== exp_a) begin
      $display("FAIL overlap1_detects actual=%b required=%b", got_a, exp_a);
      errors++;
    end
    checks++;
    if (got_b !== exp_b) begin
      $display("FAIL overlap0_detects actual=%b required=%b", got_b, exp_b);
      errors++;
    end
    checks++;
    if (a_cnt !== 8'd2) begin
      $display("FAIL overlap1_count actual=%0d required=2", a_cnt);
      errors++;
    end
    checks++;
    if ({b_cnt, b_fill, b_hist} !== {8'd1, 4'd3, 4'b1101}) begin
      $display("FAIL overlap0_state actual cnt=%0d fill=%0d hist=%b required cnt=1 fill=3 hist=1101",
               b_cnt, b_fill, b_hist);
      errors++;
    end
  endtask

  task automatic test_gating();
    int det_seen;
    det_seen = 0;
    for (int i = 0; i < 50; i++) begin
      din = i[0];
      @(posedge clk_in); #1;
      if (a_det || b_det || c_det) det_seen++;
    end
    checks++;
    if (det_seen !== 0) begin
      $display("FAIL gating_detect actual=%0d pulses required=0", det_seen);
      errors++;
    end
    checks++;
    if ({a_hist, a_fill, a_cnt, b_hist, b_fill, b_cnt} !== {4'b1101, 4'd4, 8'd2, 4'b1101, 4'd3, 8'd1}) begin
      $display("FAIL gating_hold actual a=%b/%0d/%0d b=%b/%0d/%0d required a=1101/4/2 b=1101/3/1",
               a_hist, a_fill, a_cnt, b_hist, b_fill, b_cnt);
      errors++;
    end
    do_step(1'b1);
    checks++;
    if ({b_fill, b_hist, b_det, a_hist, a_fill} !== {4'd4, 4'b1011, 1'b0, 4'b1011, 4'd4}) begin
      $display("FAIL gating_step actual b_fill=%0d b_hist=%b b_det=%b a_hist=%b a_fill=%0d required 4 1011 0 1011 4",
               b_fill, b_hist, b_det, a_hist, a_fill);
      errors++;
    end
  endtask

  task automatic test_saturation();
    int bad_det;
    bad_det = 0;
    do_clear();
    for (int i = 1; i <= 300; i++) begin
      do_step(1'b1);
      if (c_det !== (i >= 4)) bad_det++;
      if (i == 257) begin
        checks++;
        if (c_cnt !== 8'd254) begin
          $display("FAIL sat_count_257 actual=%0d required=254", c_cnt);
          errors++;
        end
      end
      if (i == 258) begin
        checks++;
        if (c_cnt !== 8'd255) begin
          $display("FAIL sat_count_258 actual=%0d required=255", c_cnt);
          errors++;
        end
      end
    end
    checks++;
    if (bad_det !== 0) begin
      $display("FAIL sat_detect actual=%0d wrong cycles required=0", bad_det);
      errors++;
    end
    checks++;
    if ({c_cnt, c_led} !== {8'd255, 1'b1}) begin
      $display("FAIL sat_final actual cnt=%0d led=%b required cnt=255 led=1", c_cnt, c_led);
      errors++;
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    do_step(1'b1); do_step(1'b1); do_step(1'b0); do_step(1'b1);
    do_step(1'b1); do_step(1'b1); do_step(1'b0);
    checks++;
    if ({b_fill, b_led, b_cnt} !== {4'd3, 1'b1, 8'd1}) begin
      $display("FAIL clear_setup actual fill=%0d led=%b cnt=%0d required fill=3 led=1 cnt=1",
               b_fill, b_led, b_cnt);
      errors++;
    end
    clear = 1'b1;
    do_step(1'b1);
    clear = 1'b0;
    checks++;
    if ({b_det, b_led, b_cnt, b_fill, b_hist} !== 18'd0) begin
      $display("FAIL clear_with_step actual det=%b led=%b cnt=%0d fill=%0d hist=%b required all 0",
               b_det, b_led, b_cnt, b_fill, b_hist);
      errors++;
    end
    do_step(1'b1); do_step(1'b1); do_step(1'b0);
    checks++;
    if (a_fill !== 4'd3) begin
      $display("FAIL reset_setup_fill actual=%0d required=3", a_fill);
      errors++;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({a_det, a_led, a_cnt, a_fill, a_hist} !== 18'd0) begin
      $display("FAIL async_reset actual=%h required=0", {a_det, a_led, a_cnt, a_fill, a_hist});
      errors++;
    end
    @(posedge clk_in); #3;
    rst = 1'b1;
    @(posedge clk_in); #1;
    do_step(1'b1); do_step(1'b1); do_step(1'b0); do_step(1'b1);
    checks++;
    if ({a_det, a_cnt, a_led, a_fill} !== {1'b1, 8'd1, 1'b1, 4'd4}) begin
      $display("FAIL after_reset_match actual det=%b cnt=%0d led=%b fill=%0d required 1 1 1 4",
               a_det, a_cnt, a_led, a_fill);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_gating();
    test_saturation();
    test_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
